// File: rtl/riscv_multicycle_ctrl_if.sv
// Memory handshake: the controller raises mem_req (and mem_write for stores) and holds them
// steady; the access completes on the first rising edge where mem_req and mem_ready are both high.
interface riscv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_req, output mem_write, input mem_ready);
  modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over a shared ALU and a unified
// memory port, raising illegal-instruction and bus-timeout traps and counting retired instructions.
module riscv_multicycle_ctrl #(
  parameter bit MEM_WAIT    = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  riscv_multicycle_ctrl_if.master bus,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    zero,
  output logic                    adr_src,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    reg_write,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              imm_src,
  output logic [4:0]              alu_control,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic [CNT_W-1:0]        instret,
  output logic [3:0]              state_dbg
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLTU = 5'b01000;
  localparam logic [4:0] ALU_SLT  = 5'b01001;
  localparam logic [4:0] ALU_SLLI = 5'b01010;
  localparam logic [4:0] ALU_SRLI = 5'b01011;
  localparam logic [4:0] ALU_SRAI = 5'b01100;
  localparam logic [4:0] ALU_BNE  = 5'b01101;
  localparam logic [4:0] ALU_BLT  = 5'b01110;
  localparam logic [4:0] ALU_BGE  = 5'b01111;
  localparam logic [4:0] ALU_LUI  = 5'b10000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  instret_q;
  logic              legal, mem_done, mem_state, timeout_hit;
  logic              trap_set;
  logic [1:0]        trap_code;
  logic              mem_req, mem_write;

  function automatic logic [4:0] r_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLLI;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRAI : ALU_SRLI;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // The ALU turns every branch condition into "zero = 1 means taken"; beq uses plain SUB.
  function automatic logic [4:0] br_alu(input logic [2:0] f3);
    case (f3)
      3'b000:         return ALU_SUB;
      3'b001:         return ALU_BNE;
      3'b100, 3'b110: return ALU_BLT;
      default:        return ALU_BGE;
    endcase
  endfunction

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OP_STORE:  legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_R:      legal = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_I: begin
        if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                       legal = 1'b1;
      end
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  assign mem_done    = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign mem_state   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // A completing access in the last allowed cycle beats the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_done && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    trap        = 1'b0;
    trap_set    = 1'b0;
    trap_code   = 2'b00;
    if (reset) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          if (mem_done) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
          if (!legal) begin
            state_next = S_TRAP;
            trap_set   = 1'b1;
            trap_code  = CAUSE_ILLEGAL;
          end else begin
            case (opcode)
              OP_LOAD, OP_STORE: state_next = S_MEMADR;
              OP_R:              state_next = S_EXECR;
              OP_I:              state_next = S_EXECI;
              OP_BRANCH:         state_next = S_BRANCH;
              OP_JAL:            state_next = S_JAL;
              OP_JALR:           state_next = S_JALR;
              OP_LUI:            state_next = S_LUI;
              default:           state_next = S_AUIPC;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
          state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_done) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_done) state_next = S_FETCH;
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = r_alu(funct3, funct7[5]);
          state_next  = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = i_alu(funct3, funct7[5]);
          state_next  = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = br_alu(funct3);
          pc_write    = zero;
          state_next  = S_FETCH;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          state_next = S_JAL;
        end
        // JAL redirects the PC and leaves OldPC+4 in ALUOut for ALUWB to write back.
        S_JAL: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          pc_write   = 1'b1;
          state_next = S_ALUWB;
        end
        S_LUI: begin
          alu_src_b   = 2'b01;
          imm_src     = IMM_U;
          alu_control = ALU_LUI;
          state_next  = S_ALUWB;
        end
        S_AUIPC: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b01;
          imm_src    = IMM_U;
          state_next = S_ALUWB;
        end
        S_TRAP: begin
          trap       = 1'b1;
          pc_src     = 1'b1;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
      if (timeout_hit) begin
        state_next = S_TRAP;
        trap_set   = 1'b1;
        trap_code  = CAUSE_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)           wait_cnt <= '0;
      else if (mem_state && !mem_done)   wait_cnt <= wait_cnt + WAIT_W'(1);
      if (trap_set) cause_q <= trap_code;
      // Trap returns refetch without retiring anything.
      if ((state_next == S_FETCH) && (state != S_FETCH) && (state != S_TRAP))
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_write = mem_write;
  assign trap_cause    = cause_q;
  assign instret       = instret_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: a per-cycle vector table of instruction sequences,
// followed by hand-written timeout, ready-wins-timeout and reset-during-store sequences.
module tb_riscv_multicycle_ctrl;
  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8,  S_BRANCH = 4'd9,  S_JAL = 4'd10,   S_JALR = 4'd11;
  localparam logic [3:0] S_LUI = 4'd12,   S_AUIPC = 4'd13,  S_TRAP = 4'd14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b00001, A_XOR = 5'b00100;
  localparam logic [4:0] A_SRAI = 5'b01100, A_BNE = 5'b01101, A_LUI = 5'b10000;
  localparam logic [2:0] I_I = 3'b000, I_S = 3'b001, I_B = 3'b010, I_J = 3'b011, I_U = 3'b100;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [21:0] ctl;
    logic [31:0] ret;
    logic [1:0]  cause;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        zero = 1'b0;
  logic        adr_src, ir_write, pc_write, pc_src, reg_write, trap;
  logic [1:0]  result_src, alu_src_a, alu_src_b, trap_cause;
  logic [2:0]  imm_src;
  logic [4:0]  alu_control;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  riscv_multicycle_ctrl_if bus ();

  riscv_multicycle_ctrl #(.MEM_WAIT(1'b1), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .trap(trap), .trap_cause(trap_cause), .instret(instret), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  // {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write,
  //  result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap}
  function automatic logic [21:0] mk(input logic req, input logic wr, input logic adr,
      input logic irw, input logic pcw, input logic pcs, input logic rw, input logic [1:0] rs,
      input logic [1:0] a, input logic [1:0] b, input logic [2:0] imm, input logic [4:0] alu,
      input logic tr);
    return {req, wr, adr, irw, pcw, pcs, rw, rs, a, b, imm, alu, tr};
  endfunction

  function automatic vec_t row(input logic rst, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic z, input logic rdy, input logic [3:0] st,
      input logic [21:0] ctl, input logic [31:0] ret, input logic [1:0] cause);
    vec_t v;
    v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.ret = ret; v.cause = cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs mid-cycle and check the current state/outputs
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    reset         = v.rst;
    opcode        = v.op;
    funct3        = v.f3;
    funct7        = v.f7;
    zero          = v.zero;
    bus.mem_ready = v.rdy;
    #1;
    check({tag, " state"}, {28'd0, state_dbg}, {28'd0, v.st});
    check({tag, " ctl"}, {10'd0, bus.mem_req, bus.mem_write, adr_src, ir_write, pc_write, pc_src,
          reg_write, result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap},
          {10'd0, v.ctl});
    check({tag, " instret"}, instret, v.ret);
    check({tag, " cause"}, {30'd0, trap_cause}, {30'd0, v.cause});
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic z, input logic rdy, input logic [3:0] st, input logic [21:0] ctl,
      input logic [31:0] ret, input logic [1:0] cause);
    tbl.push_back(row(1'b0, op, f3, f7, z, rdy, st, ctl, ret, cause));
  endtask

  initial begin
    logic [21:0] c_fstall, c_fdone, c_decb, c_decj, c_aluwb, c_trap, c_mread, c_mwrite;
    bus.mem_ready = 1'b0;
    c_fstall = mk(1,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, I_I, A_ADD, 0);
    c_fdone  = mk(1,0,0,1,1,0,0, 2'b10, 2'b00, 2'b10, I_I, A_ADD, 0);
    c_decb   = mk(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, I_B, A_ADD, 0);
    c_decj   = mk(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, I_J, A_ADD, 0);
    c_aluwb  = mk(0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, I_I, A_ADD, 0);
    c_trap   = mk(0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, I_I, A_ADD, 1);
    c_mread  = mk(1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, I_I, A_ADD, 0);
    c_mwrite = mk(1,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, I_I, A_ADD, 0);

    tbl.push_back(row(1'b1, 7'd0, 3'd0, 7'd0, 0, 0, S_FETCH, 22'd0, 0, 2'b00));
    // addi x1,x0,5
    add(OP_I, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 0, 0);
    add(OP_I, 3'b000, 7'd0, 0, 1, S_DECODE, c_decb,  0, 0);
    add(OP_I, 3'b000, 7'd0, 0, 1, S_EXECI,  mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_I, A_ADD, 0), 0, 0);
    add(OP_I, 3'b000, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 0, 0);
    // lw with three wait cycles on fetch and on the data read
    for (int i = 0; i < 3; i++) add(OP_LOAD, 3'b010, 7'd0, 0, 0, S_FETCH, c_fstall, 1, 0);
    add(OP_LOAD, 3'b010, 7'd0, 0, 1, S_FETCH,  c_fdone, 1, 0);
    add(OP_LOAD, 3'b010, 7'd0, 0, 1, S_DECODE, c_decb,  1, 0);
    add(OP_LOAD, 3'b010, 7'd0, 0, 1, S_MEMADR, mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_I, A_ADD, 0), 1, 0);
    for (int i = 0; i < 3; i++) add(OP_LOAD, 3'b010, 7'd0, 0, 0, S_MEMREAD, c_mread, 1, 0);
    add(OP_LOAD, 3'b010, 7'd0, 0, 1, S_MEMREAD, c_mread, 1, 0);
    add(OP_LOAD, 3'b010, 7'd0, 0, 1, S_MEMWB,  mk(0,0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, I_I, A_ADD, 0), 1, 0);
    // beq taken, bne not taken
    add(OP_BRANCH, 3'b000, 7'd0, 1, 1, S_FETCH,  c_fdone, 2, 0);
    add(OP_BRANCH, 3'b000, 7'd0, 1, 1, S_DECODE, c_decb,  2, 0);
    add(OP_BRANCH, 3'b000, 7'd0, 1, 1, S_BRANCH, mk(0,0,0,0,1,0,0, 2'b00, 2'b10, 2'b00, I_I, A_SUB, 0), 2, 0);
    add(OP_BRANCH, 3'b001, 7'd0, 0, 1, S_FETCH,  c_fdone, 3, 0);
    add(OP_BRANCH, 3'b001, 7'd0, 0, 1, S_DECODE, c_decb,  3, 0);
    add(OP_BRANCH, 3'b001, 7'd0, 0, 1, S_BRANCH, mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, I_I, A_BNE, 0), 3, 0);
    // jal, then jalr
    add(OP_JAL, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 4, 0);
    add(OP_JAL, 3'b000, 7'd0, 0, 1, S_DECODE, c_decj,  4, 0);
    add(OP_JAL, 3'b000, 7'd0, 0, 1, S_JAL,    mk(0,0,0,0,1,0,0, 2'b00, 2'b01, 2'b10, I_I, A_ADD, 0), 4, 0);
    add(OP_JAL, 3'b000, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 4, 0);
    add(OP_JALR, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 5, 0);
    add(OP_JALR, 3'b000, 7'd0, 0, 1, S_DECODE, c_decb,  5, 0);
    add(OP_JALR, 3'b000, 7'd0, 0, 1, S_JALR,   mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_I, A_ADD, 0), 5, 0);
    add(OP_JALR, 3'b000, 7'd0, 0, 1, S_JAL,    mk(0,0,0,0,1,0,0, 2'b00, 2'b01, 2'b10, I_I, A_ADD, 0), 5, 0);
    add(OP_JALR, 3'b000, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 5, 0);
    // illegal opcode 0000000
    add(7'd0, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 6, 0);
    add(7'd0, 3'b000, 7'd0, 0, 1, S_DECODE, c_decb,  6, 0);
    add(7'd0, 3'b000, 7'd0, 0, 1, S_TRAP,   c_trap,  6, 2'b01);
    // sub, srai, then slli with a bad funct7
    add(OP_R, 3'b000, 7'b0100000, 0, 1, S_FETCH,  c_fdone, 6, 2'b01);
    add(OP_R, 3'b000, 7'b0100000, 0, 1, S_DECODE, c_decb,  6, 2'b01);
    add(OP_R, 3'b000, 7'b0100000, 0, 1, S_EXECR,  mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, I_I, A_SUB, 0), 6, 2'b01);
    add(OP_R, 3'b000, 7'b0100000, 0, 1, S_ALUWB,  c_aluwb, 6, 2'b01);
    add(OP_I, 3'b101, 7'b0100000, 0, 1, S_FETCH,  c_fdone, 7, 2'b01);
    add(OP_I, 3'b101, 7'b0100000, 0, 1, S_DECODE, c_decb,  7, 2'b01);
    add(OP_I, 3'b101, 7'b0100000, 0, 1, S_EXECI,  mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_I, A_SRAI, 0), 7, 2'b01);
    add(OP_I, 3'b101, 7'b0100000, 0, 1, S_ALUWB,  c_aluwb, 7, 2'b01);
    add(OP_I, 3'b001, 7'b0100000, 0, 1, S_FETCH,  c_fdone, 8, 2'b01);
    add(OP_I, 3'b001, 7'b0100000, 0, 1, S_DECODE, c_decb,  8, 2'b01);
    add(OP_I, 3'b001, 7'b0100000, 0, 1, S_TRAP,   c_trap,  8, 2'b01);
    // lui, auipc
    add(OP_LUI, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 8, 2'b01);
    add(OP_LUI, 3'b000, 7'd0, 0, 1, S_DECODE, c_decb,  8, 2'b01);
    add(OP_LUI, 3'b000, 7'd0, 0, 1, S_LUI,    mk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, I_U, A_LUI, 0), 8, 2'b01);
    add(OP_LUI, 3'b000, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 8, 2'b01);
    add(OP_AUIPC, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 9, 2'b01);
    add(OP_AUIPC, 3'b000, 7'd0, 0, 1, S_DECODE, c_decb,  9, 2'b01);
    add(OP_AUIPC, 3'b000, 7'd0, 0, 1, S_AUIPC,  mk(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, I_U, A_ADD, 0), 9, 2'b01);
    add(OP_AUIPC, 3'b000, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 9, 2'b01);
    // sw with two wait cycles on the write
    add(OP_STORE, 3'b010, 7'd0, 0, 1, S_FETCH,  c_fdone, 10, 2'b01);
    add(OP_STORE, 3'b010, 7'd0, 0, 1, S_DECODE, c_decb,  10, 2'b01);
    add(OP_STORE, 3'b010, 7'd0, 0, 1, S_MEMADR, mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_S, A_ADD, 0), 10, 2'b01);
    for (int i = 0; i < 2; i++) add(OP_STORE, 3'b010, 7'd0, 0, 0, S_MEMWRITE, c_mwrite, 10, 2'b01);
    add(OP_STORE, 3'b010, 7'd0, 0, 1, S_MEMWRITE, c_mwrite, 10, 2'b01);
    // xor, then an M-extension funct7 that must trap
    add(OP_R, 3'b100, 7'd0, 0, 1, S_FETCH,  c_fdone, 11, 2'b01);
    add(OP_R, 3'b100, 7'd0, 0, 1, S_DECODE, c_decb,  11, 2'b01);
    add(OP_R, 3'b100, 7'd0, 0, 1, S_EXECR,  mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, I_I, A_XOR, 0), 11, 2'b01);
    add(OP_R, 3'b100, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 11, 2'b01);
    add(OP_R, 3'b000, 7'b0000001, 0, 1, S_FETCH,  c_fdone, 12, 2'b01);
    add(OP_R, 3'b000, 7'b0000001, 0, 1, S_DECODE, c_decb,  12, 2'b01);
    add(OP_R, 3'b000, 7'b0000001, 0, 1, S_TRAP,   c_trap,  12, 2'b01);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // fetch stalls 16 cycles -> bus-timeout trap
    for (int i = 0; i < 16; i++)
      step(row(0, OP_I, 3'b000, 7'd0, 0, 0, S_FETCH, c_fstall, 12, 2'b01), $sformatf("to_stall%0d", i));
    step(row(0, OP_I, 3'b000, 7'd0, 0, 0, S_TRAP, c_trap, 12, 2'b10), "to_trap");

    // ready on the last allowed stall cycle completes the fetch instead of trapping
    for (int i = 0; i < 15; i++)
      step(row(0, OP_I, 3'b000, 7'd0, 0, 0, S_FETCH, c_fstall, 12, 2'b10), $sformatf("rw_stall%0d", i));
    step(row(0, OP_I, 3'b000, 7'd0, 0, 1, S_FETCH,  c_fdone, 12, 2'b10), "rw_done");
    step(row(0, OP_I, 3'b000, 7'd0, 0, 1, S_DECODE, c_decb,  12, 2'b10), "rw_decode");
    step(row(0, OP_I, 3'b000, 7'd0, 0, 1, S_EXECI,
             mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_I, A_ADD, 0), 12, 2'b10), "rw_execi");
    step(row(0, OP_I, 3'b000, 7'd0, 0, 1, S_ALUWB,  c_aluwb, 12, 2'b10), "rw_aluwb");

    // reset while a store is stalled abandons it; the next store completes normally
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_FETCH,  c_fdone, 13, 2'b10), "rs_fetch");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_DECODE, c_decb,  13, 2'b10), "rs_decode");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_MEMADR,
             mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_S, A_ADD, 0), 13, 2'b10), "rs_memadr");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 0, S_MEMWRITE, c_mwrite, 13, 2'b10), "rs_stall");
    step(row(1, OP_STORE, 3'b010, 7'd0, 0, 0, S_MEMWRITE, 22'd0, 13, 2'b10), "rs_reset");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_FETCH,  c_fdone, 0, 2'b00), "rs2_fetch");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_DECODE, c_decb,  0, 2'b00), "rs2_decode");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_MEMADR,
             mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, I_S, A_ADD, 0), 0, 2'b00), "rs2_memadr");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 1, S_MEMWRITE, c_mwrite, 0, 2'b00), "rs2_write");
    step(row(0, OP_STORE, 3'b010, 7'd0, 0, 0, S_FETCH,  c_fstall, 1, 2'b00), "rs2_retired");

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
